// File: rtl/bram_frame_ctrl_if.sv
// Signal bundle between the frame controller, its stream neighbours and the block RAM port.
// The master modport is the controller's view; slave is the surrounding environment.
interface bram_frame_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 11
);
    logic          start;
    logic [AW:0]   frame_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, frame_len, s_valid, s_data, m_ready, mem_dout,
        output s_ready, m_valid, m_data, m_last, mem_we, mem_addr, mem_din, busy, done, err
    );

    modport slave (
        output start, frame_len, s_valid, s_data, m_ready, mem_dout,
        input  s_ready, m_valid, m_data, m_last, mem_we, mem_addr, mem_din, busy, done, err
    );
endinterface

// File: rtl/bram_frame_ctrl.sv
// Frame controller: fills the block RAM from an input stream, then replays the frame
// from address 0 through a 2-entry skid FIFO that hides the RAM's 1-cycle read latency.
//
// state | meaning
// IDLE  | waiting for a legal start; illegal lengths pulse err
// WRITE | accepting frame words into RAM at wr_ptr
// READ  | issuing RAM reads and draining the output FIFO until the last word
module bram_frame_ctrl #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input logic               clk,
    input logic               rst_n,
    bram_frame_ctrl_if.master bus
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  WRITE   = 2'd1;
    localparam logic [1:0]  READ    = 2'd2;
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    logic [1:0]    state;
    logic [AW:0]   len;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   out_cnt;
    logic [DW-1:0] fifo_mem [2];
    logic          fifo_wsel;
    logic          fifo_rsel;
    logic [1:0]    fifo_cnt;
    logic          inflight;
    logic          done_q;
    logic          err_q;

    logic          wr_fire;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;

    // Occupancy counts words already buffered plus the read in flight, net of this cycle's pop.
    always_comb begin
        wr_fire = (state == WRITE) && bus.s_valid;
        pop     = bus.m_valid && bus.m_ready;
        occ     = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        issue   = (state == READ) && (rd_ptr < len) && (occ < 3'd2);
    end

    assign bus.s_ready  = (state == WRITE);
    assign bus.mem_we   = wr_fire;
    assign bus.mem_addr = wr_fire ? wr_ptr[AW-1:0] : (issue ? rd_ptr[AW-1:0] : '0);
    assign bus.mem_din  = wr_fire ? bus.s_data : '0;
    assign bus.m_valid  = (fifo_cnt != 2'd0);
    assign bus.m_data   = bus.m_valid ? fifo_mem[fifo_rsel] : '0;
    assign bus.m_last   = bus.m_valid && (out_cnt == (len - ONE));
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_cnt     <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wsel   <= 1'b0;
            fifo_rsel   <= 1'b0;
            fifo_cnt    <= 2'd0;
            inflight    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.frame_len == '0) || (bus.frame_len > MAX_LEN)) begin
                            err_q <= 1'b1;
                        end else begin
                            len    <= bus.frame_len;
                            wr_ptr <= '0;
                            state  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr == (len - ONE)) begin
                            rd_ptr  <= '0;
                            out_cnt <= '0;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + ONE;
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + ONE;
                        if (bus.m_last) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // RAM data appears one cycle after its address; capture it then.
            inflight <= issue;
            if (inflight) begin
                fifo_mem[fifo_wsel] <= bus.mem_dout;
                fifo_wsel           <= ~fifo_wsel;
            end
            if (pop) begin
                fifo_rsel <= ~fifo_rsel;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Scoreboard bench for bram_frame_ctrl with a behavioural 16x2048 registered-read RAM.
module tb_bram_frame_ctrl;
    localparam int DW = 16;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bram_frame_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    bram_frame_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:2047];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW-1:0] words [0:2047];
    logic [DW:0] exp_q [$];
    int wr_cnt = 0;
    int exp_len = 0;
    int last_wr_cyc = 0;
    int first_valid_cyc = 0;
    int last_pop_cyc = 0;
    int done_cnt = 0;
    bit first_pending = 0;
    bit stall_hold = 0;
    logic [DW:0] hold;
    bit rdy_pat_en = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        bus.m_ready = rdy_pat_en ? pat[cyc % 6] : 1'b1;
    end

    // Monitor: RAM write port, output stream against scoreboard, stall stability, pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 0;
        end else begin
            if (bus.mem_we) begin
                if (wr_cnt >= exp_len) begin
                    chk("spurious_we", 1, 0);
                end else begin
                    chk("wr_addr", int'(bus.mem_addr), wr_cnt);
                    chk("wr_din", int'(bus.mem_din), int'(words[wr_cnt]));
                    if (wr_cnt == exp_len - 1) begin
                        last_wr_cyc = cyc;
                        first_pending = 1;
                    end
                    wr_cnt++;
                end
            end
            if (bus.m_valid) begin
                if (first_pending) begin
                    chk("first_valid_latency", cyc - last_wr_cyc, 3);
                    first_valid_cyc = cyc;
                    first_pending = 0;
                end
                if (stall_hold) chk("stall_stable", int'({bus.m_last, bus.m_data}), int'(hold));
                if (bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_underflow", 1, 0);
                    end else begin
                        logic [DW:0] e;
                        e = exp_q.pop_front();
                        chk("m_data", int'(bus.m_data), int'(e[DW-1:0]));
                        chk("m_last", int'(bus.m_last), int'(e[DW]));
                    end
                    last_pop_cyc = cyc;
                end
                stall_hold = !bus.m_ready;
                hold = {bus.m_last, bus.m_data};
            end else begin
                if (stall_hold) chk("valid_dropped", 0, 1);
                stall_hold = 0;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic begin_frame(input int len);
        bus.start = 1'b1;
        bus.frame_len = len[AW:0];
        exp_len = len;
        wr_cnt = 0;
        first_pending = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_word(input int i, input int len, input int gap);
        bit ok;
        repeat (gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        exp_q.push_back({(i == len - 1), words[i]});
        bus.s_valid = 1'b1;
        bus.s_data = words[i];
        ok = 0;
        for (int b = 0; b < 100 && !ok; b++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        if (!ok) chk("s_ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit ok;
        int d0;
        d0 = done_cnt;
        ok = 0;
        for (int b = 0; b < bound && !ok; b++) begin
            @(negedge clk);
            ok = bus.done;
        end
        chk({nm, "_done_seen"}, int'(ok), 1);
        chk({nm, "_busy_low"}, int'(bus.busy), 0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, int'(bus.done), 0);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input int len, input string nm);
        begin_frame(len);
        for (int i = 0; i < len; i++) send_word(i, len, 0);
        wait_done(len * 4 + 50, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.frame_len = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        #12;
        chk("reset_outputs", int'({bus.s_ready, bus.m_valid, bus.m_last, bus.mem_we, bus.busy,
                                   bus.done, bus.err, bus.mem_addr, bus.mem_din, bus.m_data}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort mid-frame with an asynchronous reset.
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        begin_frame(4);
        send_word(0, 4, 0);
        send_word(1, 4, 0);
        bus.s_valid = 1'b1;
        chk("busy_before_abort", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({bus.s_ready, bus.m_valid, bus.m_last, bus.mem_we, bus.busy,
                                        bus.done, bus.err, bus.mem_addr, bus.mem_din, bus.m_data}), 0);
        bus.s_valid = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        exp_len = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(4, "len4");

        rdy_pat_en = 1;
        for (int i = 0; i < 8; i++) words[i] = 16'hA000 + 16'(i * 16'h0111);
        run_frame(8, "len8_bp");
        rdy_pat_en = 0;

        // Illegal lengths with s_valid asserted in IDLE.
        exp_len = 0;
        wr_cnt = 0;
        bus.s_valid = 1'b1;
        bus.s_data = 16'hDEAD;
        bus.start = 1'b1; bus.frame_len = 12'd0;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("err_len0", int'(bus.err), 1);
        chk("err_len0_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("err_len0_pulse", int'(bus.err), 0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.frame_len = 12'd2049;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("err_len2049", int'(bus.err), 1);
        chk("err_len2049_busy", int'(bus.busy), 0);
        @(negedge clk);
        chk("err_len2049_pulse", int'(bus.err), 0);
        bus.s_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 2048; i++) words[i] = 16'(i);
        run_frame(2048, "len2048");
        chk("len2048_throughput", last_pop_cyc - first_valid_cyc, 2047);

        // Single word with input gaps and an ignored start during WRITE.
        words[0] = 16'hBEEF;
        begin_frame(1);
        bus.s_valid = 1'b0;
        bus.start = 1'b1;
        bus.frame_len = 12'd5;
        @(negedge clk);
        chk("len1_busy_in_write", int'(bus.busy), 1);
        @(posedge clk); #1 bus.start = 1'b0;
        send_word(0, 1, 2);
        wait_done(50, "len1");
        repeat (3) @(negedge clk);
        chk("len1_idle_after", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
